// File: rtl/acc_axil_selftest_master.sv
// AXI4-Lite self-test master for the accelerator register slave.
// On an INIT_AXI_TXN rising edge it writes an incrementing pattern to
// consecutive registers, reads every register back and compares it, then
// holds TXN_DONE high with ERROR reporting any failure seen on the way.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | after reset, waiting for the first start
// ST_WRITE | one write in flight: AW/W valid, then the B response
// ST_READ  | one read in flight: AR valid, then the R data
// ST_DONE  | sequence finished or aborted; TXN_DONE held until next start
`timescale 1ns/1ps
module acc_axil_selftest_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = '0,
    parameter int C_M_TRANSACTIONS_NUM = 4,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0] C_M_START_DATA_VALUE = C_M_AXI_DATA_WIDTH'(1),
    parameter int C_M_TIMEOUT_CYCLES = 1024
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            INIT_AXI_TXN,
    output logic                            TXN_DONE,
    output logic                            ERROR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DONE} state_t;

    localparam int TW = $clog2(C_M_TIMEOUT_CYCLES + 1);
    localparam logic [4:0]    LAST_IDX   = 5'(C_M_TRANSACTIONS_NUM - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(C_M_TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [4:0]    idx;
    logic [4:0]    next_idx;
    logic [TW-1:0] timer;
    logic          init_q;
    logic          start;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;

    function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] addr_of(input logic [4:0] i);
        return C_M_TARGET_SLAVE_BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(i) << 2);
    endfunction

    function automatic logic [C_M_AXI_DATA_WIDTH-1:0] data_of(input logic [4:0] i);
        return C_M_START_DATA_VALUE + C_M_AXI_DATA_WIDTH'(i);
    endfunction

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    assign start    = INIT_AXI_TXN & ~init_q;
    assign next_idx = idx + 5'd1;
    assign aw_hs    = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs     = M_AXI_WVALID  & M_AXI_WREADY;
    assign b_hs     = M_AXI_BREADY  & M_AXI_BVALID;
    assign ar_hs    = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs     = M_AXI_RREADY  & M_AXI_RVALID;
    assign any_hs   = aw_hs | w_hs | b_hs | ar_hs | r_hs;

    // Sequencer: write pass, read-compare pass, completion and watchdog abort.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= ST_IDLE;
            idx           <= '0;
            timer         <= '0;
            init_q        <= 1'b0;
            TXN_DONE      <= 1'b0;
            ERROR         <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            init_q <= INIT_AXI_TXN;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state         <= ST_WRITE;
                        idx           <= '0;
                        timer         <= '0;
                        TXN_DONE      <= 1'b0;
                        ERROR         <= 1'b0;
                        M_AXI_AWADDR  <= addr_of(5'd0);
                        M_AXI_WDATA   <= data_of(5'd0);
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (aw_hs) M_AXI_AWVALID <= 1'b0;
                    if (w_hs)  M_AXI_WVALID  <= 1'b0;
                    // one-cycle BREADY pulse in the cycle after BVALID is seen
                    M_AXI_BREADY <= M_AXI_BVALID & ~M_AXI_BREADY;
                    if (b_hs) begin
                        // SLVERR/DECERR both have bit 1 set
                        if (M_AXI_BRESP > 2'b01) ERROR <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state         <= ST_READ;
                            idx           <= '0;
                            M_AXI_ARADDR  <= addr_of(5'd0);
                            M_AXI_ARVALID <= 1'b1;
                        end else begin
                            idx           <= next_idx;
                            M_AXI_AWADDR  <= addr_of(next_idx);
                            M_AXI_WDATA   <= data_of(next_idx);
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (ar_hs) M_AXI_ARVALID <= 1'b0;
                    M_AXI_RREADY <= M_AXI_RVALID & ~M_AXI_RREADY;
                    if (r_hs) begin
                        if (M_AXI_RRESP > 2'b01 || M_AXI_RDATA != data_of(idx)) ERROR <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state    <= ST_DONE;
                            TXN_DONE <= 1'b1;
                        end else begin
                            idx           <= next_idx;
                            M_AXI_ARADDR  <= addr_of(next_idx);
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Something is always pending while WRITE/READ, so the watchdog
            // runs for the whole phase and restarts on any handshake.
            if (state == ST_WRITE || state == ST_READ) begin
                if (any_hs) begin
                    timer <= '0;
                end else if (timer == TIMER_LAST) begin
                    state         <= ST_DONE;
                    TXN_DONE      <= 1'b1;
                    ERROR         <= 1'b1;
                    M_AXI_AWVALID <= 1'b0;
                    M_AXI_WVALID  <= 1'b0;
                    M_AXI_BREADY  <= 1'b0;
                    M_AXI_ARVALID <= 1'b0;
                    M_AXI_RREADY  <= 1'b0;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_axil_selftest_master.sv
// Self-checking bench: a reactive AXI4-Lite slave with configurable latency
// and fault injection, plus a transaction-level reference model of the
// expected write/read sequence and error outcome.
`timescale 1ns/1ps
module tb_acc_axil_selftest_master;

    localparam int          N     = 4;
    localparam int          TO    = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] START = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        ARESET, INIT;
    logic        TXN_DONE, ERROR;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;

    always #5 clk = ~clk;

    acc_axil_selftest_master #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
        .C_M_TARGET_SLAVE_BASE_ADDR(BASE), .C_M_TRANSACTIONS_NUM(N),
        .C_M_START_DATA_VALUE(START), .C_M_TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(clk), .ARESET(ARESET), .INIT_AXI_TXN(INIT),
        .TXN_DONE(TXN_DONE), .ERROR(ERROR),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP),
        .M_AXI_RVALID(RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- slave configuration and logs ----------------
    int          aw_delay, w_delay, b_delay, ar_delay, r_delay;
    bit          rnd, bad_en, ar_block;
    logic [31:0] bad_addr, bad_data;
    int          berr_idx;

    logic [31:0] log_aw[$], log_w[$], log_ar[$];
    int          b_cnt, r_cnt, wr_idx;
    logic [31:0] mem [16];

    int          aw_seen, w_seen, ar_seen, b_wait, r_wait;
    bit          aw_got, w_got, r_pend, prev_awv;
    bit          aw_hs_q, w_hs_q, b_hs_q, ar_hs_q, r_hs_q;
    logic [31:0] aw_addr_l, w_data_l, ar_addr_l, r_addr, wa_keep, wd_keep;

    task automatic slave_clear();
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        BRESP = 2'b00; RRESP = 2'b00; RDATA = '0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; b_wait = b_delay; r_wait = r_delay;
        aw_got = 0; w_got = 0; r_pend = 0; prev_awv = 0;
        aw_hs_q = 0; w_hs_q = 0; b_hs_q = 0; ar_hs_q = 0; r_hs_q = 0;
    endtask

    // Slave reacts on the falling edge; handshakes flagged here complete at the next rising edge.
    initial begin
        slave_clear();
        forever begin
            @(negedge clk);
            if (ARESET) begin
                slave_clear();
            end else begin
                if (aw_hs_q) begin
                    log_aw.push_back(aw_addr_l);
                    wa_keep = aw_addr_l;
                    chk("awvalid_drop", M_AXI_AWVALID, 0);
                    AWREADY = 0; aw_seen = 0; aw_got = 1;
                    if (rnd) aw_delay = $urandom_range(0, 3);
                end
                if (w_hs_q) begin
                    log_w.push_back(w_data_l);
                    wd_keep = w_data_l;
                    chk("wvalid_drop", M_AXI_WVALID, 0);
                    WREADY = 0; w_seen = 0; w_got = 1;
                    if (rnd) w_delay = $urandom_range(0, 3);
                end
                if (b_hs_q) begin
                    BVALID = 0; BRESP = 2'b00; b_cnt++;
                    chk("bready_pulse", M_AXI_BREADY, 0);
                    b_wait = rnd ? int'($urandom_range(0, 3)) : b_delay;
                end
                if (ar_hs_q) begin
                    log_ar.push_back(ar_addr_l);
                    chk("arvalid_drop", M_AXI_ARVALID, 0);
                    ARREADY = 0; ar_seen = 0; r_pend = 1; r_addr = ar_addr_l;
                    r_wait = rnd ? int'($urandom_range(0, 3)) : r_delay;
                    if (rnd) ar_delay = $urandom_range(0, 3);
                end
                if (r_hs_q) begin
                    RVALID = 0; r_cnt++;
                    chk("rready_pulse", M_AXI_RREADY, 0);
                end

                if (M_AXI_AWVALID && !prev_awv) chk("aw_w_together", M_AXI_WVALID, 1);
                prev_awv = M_AXI_AWVALID;

                if (M_AXI_AWVALID && !AWREADY) begin
                    if (aw_seen >= aw_delay) AWREADY = 1; else aw_seen++;
                end
                if (M_AXI_WVALID && !WREADY) begin
                    if (w_seen >= w_delay) WREADY = 1; else w_seen++;
                end
                if (aw_got && w_got && !BVALID) begin
                    if (b_wait == 0) begin
                        BVALID = 1;
                        BRESP  = (wr_idx == berr_idx) ? 2'b10 : 2'b00;
                        mem[4'((wa_keep - BASE) >> 2)] = wd_keep;
                        aw_got = 0; w_got = 0; wr_idx++;
                    end else begin
                        b_wait--;
                    end
                end
                if (M_AXI_ARVALID && !ARREADY && !ar_block) begin
                    if (ar_seen >= ar_delay) ARREADY = 1; else ar_seen++;
                end
                if (r_pend && !RVALID) begin
                    if (r_wait == 0) begin
                        RVALID = 1;
                        RDATA  = (bad_en && r_addr == bad_addr) ? bad_data : mem[4'((r_addr - BASE) >> 2)];
                        r_pend = 0;
                    end else begin
                        r_wait--;
                    end
                end

                aw_hs_q = M_AXI_AWVALID && AWREADY; aw_addr_l = M_AXI_AWADDR;
                w_hs_q  = M_AXI_WVALID && WREADY;   w_data_l  = M_AXI_WDATA;
                b_hs_q  = M_AXI_BREADY && BVALID;
                ar_hs_q = M_AXI_ARVALID && ARREADY; ar_addr_l = M_AXI_ARADDR;
                r_hs_q  = M_AXI_RREADY && RVALID;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_addr(input int i);
        return BASE + 32'(4 * i);
    endfunction

    function automatic logic [31:0] exp_data(input int i);
        return START + 32'(i);
    endfunction

    function automatic bit model_err();
        bit e = 0;
        for (int i = 0; i < N; i++) begin
            if (bad_en && exp_addr(i) == bad_addr && bad_data != exp_data(i)) e = 1;
            if (i == berr_idx) e = 1;
        end
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic configure(input int awd, input int wd, input int bd, input int ard, input int rd,
                             input bit rnd_i, input bit bad_en_i, input logic [31:0] bad_addr_i,
                             input logic [31:0] bad_data_i, input int berr_i, input bit ar_block_i);
        @(posedge clk); #2;
        aw_delay = awd; w_delay = wd; b_delay = bd; ar_delay = ard; r_delay = rd;
        rnd = rnd_i; bad_en = bad_en_i; bad_addr = bad_addr_i; bad_data = bad_data_i;
        berr_idx = berr_i; ar_block = ar_block_i;
        log_aw.delete(); log_w.delete(); log_ar.delete();
        b_cnt = 0; r_cnt = 0; wr_idx = 0; b_wait = bd;
        for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
    endtask

    task automatic start_pulse();
        @(posedge clk); #2 INIT = 1;
        @(posedge clk);
        @(posedge clk); #2 INIT = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c = 0;
        while (!TXN_DONE && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(tag, TXN_DONE, 1);
        @(negedge clk);
    endtask

    task automatic check_run(input string tag);
        chk({tag, "_done"}, TXN_DONE, 1);
        chk({tag, "_error"}, ERROR, 32'(model_err()));
        chk({tag, "_aw_cnt"}, log_aw.size(), N);
        chk({tag, "_w_cnt"}, log_w.size(), N);
        chk({tag, "_b_cnt"}, b_cnt, N);
        chk({tag, "_ar_cnt"}, log_ar.size(), N);
        chk({tag, "_r_cnt"}, r_cnt, N);
        for (int i = 0; i < N; i++) begin
            if (i < log_aw.size()) chk({tag, "_awaddr"}, log_aw[i], exp_addr(i));
            if (i < log_w.size())  chk({tag, "_wdata"}, log_w[i], exp_data(i));
            if (i < log_ar.size()) chk({tag, "_araddr"}, log_ar[i], exp_addr(i));
        end
    endtask

    task automatic run(input string tag);
        start_pulse();
        wait_done({tag, "_finish"}, 400);
        check_run(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        ARESET = 1; INIT = 0;
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        rnd = 0; bad_en = 0; ar_block = 0; bad_addr = '0; bad_data = '0; berr_idx = 99;
        b_cnt = 0; r_cnt = 0; wr_idx = 0;
        repeat (3) @(posedge clk);
        #2 ARESET = 0;
        @(negedge clk);
        chk("rst_awvalid", M_AXI_AWVALID, 0);
        chk("rst_wvalid", M_AXI_WVALID, 0);
        chk("rst_bready", M_AXI_BREADY, 0);
        chk("rst_arvalid", M_AXI_ARVALID, 0);
        chk("rst_rready", M_AXI_RREADY, 0);
        chk("rst_done", TXN_DONE, 0);
        chk("rst_error", ERROR, 0);
        chk("rst_awaddr", M_AXI_AWADDR, 0);
        chk("rst_wdata", M_AXI_WDATA, 0);
        chk("rst_araddr", M_AXI_ARADDR, 0);
        chk("awprot", M_AXI_AWPROT, 0);
        chk("arprot", M_AXI_ARPROT, 0);
        chk("wstrb", M_AXI_WSTRB, 4'hF);

        configure(0, 0, 0, 0, 0, 0, 0, '0, '0, 99, 0);
        run("clean");

        configure(0, 0, 1, 0, 1, 0, 1, 32'h8, 32'h5, 99, 0);
        run("bad_rdata");

        configure(1, 1, 0, 1, 0, 0, 0, '0, '0, 1, 0);
        run("bresp_err");

        configure(3, 0, 0, 0, 0, 0, 0, '0, '0, 99, 0);
        run("w_first");
        configure(0, 3, 0, 0, 0, 0, 0, '0, '0, 99, 0);
        run("aw_first");
        configure(2, 2, 0, 0, 0, 0, 0, '0, '0, 99, 0);
        run("aw_w_same");

        // read address never accepted: watchdog abort
        configure(0, 0, 0, 0, 0, 0, 0, '0, '0, 99, 1);
        start_pulse();
        c = 0;
        while (!M_AXI_ARVALID && c < 200) begin @(negedge clk); c++; end
        chk("to_arvalid_seen", M_AXI_ARVALID, 1);
        c = 0;
        while (!TXN_DONE && c < 40) begin @(negedge clk); c++; end
        chk("to_done", TXN_DONE, 1);
        chk("to_latency_ok", 32'(c <= TO + 2), 1);
        chk("to_arvalid_low", M_AXI_ARVALID, 0);
        chk("to_error", ERROR, 1);
        chk("to_w_cnt", b_cnt, N);
        chk("to_ar_cnt", log_ar.size(), 0);

        // reset in the middle of the write phase
        configure(2, 2, 1, 1, 1, 0, 0, '0, '0, 99, 0);
        start_pulse();
        repeat (3) @(negedge clk);
        @(posedge clk); #2 ARESET = 1;
        @(posedge clk); #2 ARESET = 0;
        @(negedge clk);
        chk("mrst_awvalid", M_AXI_AWVALID, 0);
        chk("mrst_wvalid", M_AXI_WVALID, 0);
        chk("mrst_arvalid", M_AXI_ARVALID, 0);
        chk("mrst_bready", M_AXI_BREADY, 0);
        chk("mrst_done", TXN_DONE, 0);
        chk("mrst_error", ERROR, 0);

        // fresh sequence with a second start while busy
        configure(2, 2, 1, 1, 1, 0, 0, '0, '0, 99, 0);
        start_pulse();
        repeat (2) @(posedge clk);
        start_pulse();
        wait_done("busy_finish", 400);
        check_run("busy_ignore");

        for (int k = 0; k < 6; k++) begin
            configure($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1,
                      1'($urandom_range(0, 1)), exp_addr($urandom_range(0, N - 1)),
                      $urandom, $urandom_range(0, N + 2), 0);
            run("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
